i2s_mixer_n: RTL

N-channel I2S mixer. Deserialises `n_ch` Philips-format I2S input lines that share one `bclk`/`lrclk` pair. Applies per-channel attenuation, inversion and mute, sums each stereo slot with saturation, and reserialises the result onto one I2S output line. It is the parametrised successor to the two-input `sum` / `mixer` chain, and sits between `i2s_clk`/microphone inputs and `i2s_des`/DAC outputs in board tops.

---
 rtl/i2s_mix_pkg.sv | 22 ++
 rtl/i2s_slot_capture.sv | 55 +++++
 rtl/i2s_mixer_n.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_mix_pkg.sv
// Shared types and width/limit helpers for the N-channel I2S mixer.
package i2s_mix_pkg;

  typedef enum logic {
    SLOT_L = 1'b0,
    SLOT_R = 1'b1
  } slot_e;

  // Sum of n_ch terms of w_data+1 bits needs log2(n_ch) guard bits.
  function automatic int acc_width(input int w_data, input int n_ch);
    return w_data + 1 + $clog2(n_ch);
  endfunction

  function automatic longint sat_max(input int w_data);
    return (longint'(1) <<< (w_data - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w_data);
    return -(longint'(1) <<< (w_data - 1));
  endfunction

endpackage

// File: rtl/i2s_slot_capture.sv
// bclk edge detection, slot boundary detection and bit position tracking,
// shared by all input lines of the mixer.
module i2s_slot_capture #(
  parameter int  w_data = 24,
  localparam int PW     = $clog2(w_data)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bclk,
  input  logic          lrclk,
  output logic          boundary,
  output logic          fall,
  output logic          cap_en,
  output logic [PW-1:0] cap_pos
);

  localparam int IW = $clog2(w_data + 2);

  logic          bclk_q;
  logic          lr_q;
  logic          rise;
  logic [IW-1:0] bit_idx;
  logic [IW-1:0] idx_nxt;

  assign rise     = bclk & ~bclk_q;
  assign fall     = ~bclk & bclk_q;
  assign boundary = rise & (lrclk ^ lr_q);

  // Index 0 is the delay bit of the I2S frame; MSB lands at index 1.
  always_comb begin
    idx_nxt = bit_idx;
    if (boundary)
      idx_nxt = '0;
    else if (bit_idx != IW'(w_data + 1))
      idx_nxt = bit_idx + 1'b1;
  end

  assign cap_en  = rise && (idx_nxt != '0) && (idx_nxt <= IW'(w_data));
  assign cap_pos = PW'(w_data - int'(idx_nxt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_q  <= 1'b0;
      lr_q    <= 1'b0;
      bit_idx <= '0;
    end else begin
      bclk_q <= bclk;
      if (rise) begin
        lr_q    <= lrclk;
        bit_idx <= idx_nxt;
      end
    end
  end

endmodule

// File: rtl/i2s_mixer_n.sv
// N-channel I2S mixer: deserialise n_ch lines, scale/negate/mute each,
// saturating sum per slot, reserialise onto one I2S line.
module i2s_mixer_n
  import i2s_mix_pkg::*;
#(
  parameter int n_ch    = 4,
  parameter int w_data  = 24,
  parameter int w_shift = $clog2(w_data)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bclk,
  input  logic                      lrclk,
  input  logic [n_ch-1:0]           sd_in,
  input  logic [n_ch*w_shift-1:0]   shift,
  input  logic [n_ch-1:0]           minus,
  input  logic [n_ch-1:0]           mute,
  output logic                      sd_out,
  output logic [w_data-1:0]         out_l,
  output logic [w_data-1:0]         out_r,
  output logic                      out_valid,
  output logic                      out_lr,
  output logic                      clip
);

  localparam int AW = acc_width(w_data, n_ch);
  localparam int PW = $clog2(w_data);
  localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(w_data));
  localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(w_data));

  logic          boundary;
  logic          fall;
  logic          cap_en;
  logic [PW-1:0] cap_pos;
  logic          synced;

  logic          s1_valid;
  slot_e         s1_lr;
  logic          s2_valid;
  slot_e         s2_lr;

  logic signed [w_data:0]   terms [n_ch];
  logic signed [AW-1:0]     acc;
  logic        [w_data-1:0] sat_val;
  logic                     sat_clip;
  logic        [w_data-1:0] osr;

  i2s_slot_capture #(
    .w_data (w_data)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .boundary (boundary),
    .fall     (fall),
    .cap_en   (cap_en),
    .cap_pos  (cap_pos)
  );

  // The slot running when reset is released is partial; skip its result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      synced <= 1'b0;
    else if (boundary)
      synced <= 1'b1;
  end

  for (genvar c = 0; c < n_ch; c++) begin : g_ch
    logic        [w_data-1:0]  cap;
    logic        [w_data-1:0]  s1_cap;
    logic        [w_shift-1:0] s1_shift;
    logic                      s1_minus;
    logic                      s1_mute;
    logic signed [w_data:0]    scaled;
    logic signed [w_data:0]    term_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        cap <= '0;
      else if (boundary)
        cap <= '0;
      else if (cap_en)
        cap[cap_pos] <= sd_in[c];
    end

    // Controls are sampled with the finished slot so they change per slot only.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_cap   <= '0;
        s1_shift <= '0;
        s1_minus <= 1'b0;
        s1_mute  <= 1'b0;
      end else if (boundary && synced) begin
        s1_cap   <= cap;
        s1_shift <= shift[c*w_shift +: w_shift];
        s1_minus <= minus[c];
        s1_mute  <= mute[c];
      end
    end

    assign scaled = $signed({s1_cap[w_data-1], s1_cap}) >>> s1_shift;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        term_q <= '0;
      else if (s1_mute)
        term_q <= '0;
      else if (s1_minus)
        term_q <= -scaled;
      else
        term_q <= scaled;
    end

    assign terms[c] = term_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_lr    <= SLOT_L;
      s2_valid <= 1'b0;
      s2_lr    <= SLOT_L;
    end else begin
      s1_valid <= boundary & synced;
      if (boundary)
        s1_lr <= lrclk ? SLOT_L : SLOT_R;
      s2_valid <= s1_valid;
      s2_lr    <= s1_lr;
    end
  end

  always_comb begin
    acc = '0;
    for (int c = 0; c < n_ch; c++)
      acc = acc + AW'(terms[c]);
  end

  always_comb begin
    sat_val  = acc[w_data-1:0];
    sat_clip = 1'b0;
    if (acc > SAT_HI) begin
      sat_val  = SAT_HI[w_data-1:0];
      sat_clip = 1'b1;
    end else if (acc < SAT_LO) begin
      sat_val  = SAT_LO[w_data-1:0];
      sat_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      out_lr    <= 1'b0;
      clip      <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      clip      <= s2_valid & sat_clip;
      if (s2_valid) begin
        out_lr <= s2_lr;
        if (s2_lr == SLOT_R)
          out_r <= sat_val;
        else
          out_l <= sat_val;
      end
    end
  end

  // Boundary load wins over fall; the fall after it puts the MSB at bit 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      osr    <= '0;
      sd_out <= 1'b0;
    end else if (boundary) begin
      osr <= lrclk ? out_r : out_l;
    end else if (fall) begin
      sd_out <= osr[w_data-1];
      osr    <= {osr[w_data-2:0], 1'b0};
    end
  end

endmodule
